mire_wb_writer: RTL and testbench
=================================

Name: mire_wb_writer

Overview:
- Wishbone master that fills the framebuffer in SDRAM with a test pattern, one RGB565 pixel per write cycle.
- Sits directly upstream of the VGA scan-out stage, which reads the same buffer through the same Wishbone bus.
- Pixel layout matches the scan-out decode: R=[4:0], G=[10:5], B=[15:11].
- Byte address of pixel n = BASE_ADR + 2*n, raster order.

Parameters:
- HDISP, 640, pixels per line; must be a multiple of 8.
- VDISP, 480, lines per frame.
- BASE_ADR, 32'h0, byte address of pixel (0,0).
- AUTO, 0: if 1, a new fill starts automatically after every DONE, with no START needed.

Ports:
- CLK  in  1  Wishbone/system clock; the only clock.
- RST_N  in  1  asynchronous reset, active-low.
- START  in  1  one-cycle request to fill one frame; ignored unless in IDLE.
- PATTERN  in  2  pattern select, sampled on leaving IDLE.
- SCROLL  in  1  animate pattern 1/2 per frame, sampled on leaving IDLE.
- COLOR  in  16  solid colour for pattern 3, sampled on leaving IDLE.
- BUSY  out  1  high in WRITE and DONE.
- DONE  out  1  one-cycle pulse after the last pixel's ack.
- FRAME_CNT  out  8  completed fills, wraps 255->0.
- wb_cyc  out  1  Wishbone cycle.
- wb_stb  out  1  Wishbone strobe.
- wb_we  out  1  write enable; constant 1.
- wb_sel  out  2  byte selects; constant 2'b11.
- wb_adr  out  32  byte address.
- wb_dat_ms  out  16  pixel data.
- wb_ack  in  1  slave acknowledge.

Behaviour:
- Reset (async assert, sync deassert via the RST_N input directly):
  - State = IDLE; x, y, pix and FRAME_CNT are 0.
  - wb_cyc = wb_stb = 0; BUSY = 0; DONE = 0.
  - wb_adr and wb_dat_ms are 0.
- Reset mid-cycle drops wb_stb/wb_cyc in the same instant. A pending ack is ignored, and the partial frame is abandoned.
- FSM states: IDLE, WRITE, DONE.
  - IDLE -> WRITE when START=1, or unconditionally when AUTO=1.
    - On this transition, latch PATTERN, SCROLL and COLOR.
    - Latch off = SCROLL ? {FRAME_CNT,2'b00} : 0 (10 bits).
    - Clear x, y and pix.
  - WRITE: wb_cyc = wb_stb = 1 continuously.
    - wb_adr and wb_dat_ms are registered and change only on the cycle after an ack.
    - On wb_ack: pix++.
      - Then x++; if x == HDISP-1, x = 0 and y++.
    - On ack with pix == HDISP*VDISP-1: go to DONE. stb/cyc are 0 in DONE.
  - DONE: for one cycle, DONE=1 and FRAME_CNT++, then go to IDLE.
    - START asserted during WRITE or DONE is dropped, not queued.
- Back-to-back writes: 1 pixel per cycle when the slave acks every cycle. With registered outputs, the next address must be valid on the cycle after an ack. Zero-wait ack therefore requires the next address/data to be precomputed from the x/y values that follow.
- Pixel data is a function of (x, y, latched settings). xs = (x + off) mod 1024 (10-bit wrap, unrelated to HDISP).
  - Pattern 0: 8 vertical bars, each HDISP/8 wide, uses x (no scroll). Colours from left:
    - 16'hFFFF white, 16'h07FF yellow, 16'hFFE0 cyan, 16'h07E0 green,
    - 16'hF81F magenta, 16'h001F red, 16'hF800 blue, 16'h0000 black.
    - Bar index comes from a running counter. No divider is used.
  - Pattern 1: checkerboard of 32x32 cells. xs[5]^y[5] = 1 gives 16'hFFFF, otherwise 16'h0000.
  - Pattern 2: gradient. R = xs[9:5], G = y[8:3], B = ~xs[9:5].
  - Pattern 3: latched COLOR.
- wb_adr = BASE_ADR + {pix,1'b0}, 32-bit add, wraps modulo 2^32.

Test Plan:
- HDISP=16, VDISP=4, AUTO=0, PATTERN=0, ack every cycle, one START pulse:
  - 64 writes to addresses 0x00..0x7E.
  - Data sequence is 2 pixels each of FFFF, 07FF, FFE0, 07E0, F81F, 001F, F800, 0000, repeated over 4 lines.
  - DONE pulses once, 1 cycle after the 64th ack.
  - FRAME_CNT = 1.
- Same run with ack delayed by random 0-5 cycles:
  - wb_adr and wb_dat_ms are stable while stb is high and unacked.
  - Sequence is identical to the previous scenario.
- PATTERN=1, SCROLL=1, HDISP=64, VDISP=2, three frames:
  - Frame k's pixel (0,0) = 16'h0000, since off = 4k and bit 5 stays clear for k < 8.
  - Frame 0 pixel (32,0) = 16'hFFFF.
  - FRAME_CNT goes 1, 2, 3.
- START pulsed mid-frame and during DONE: no extra frame, FRAME_CNT advances by 1 only.
- RST_N low at pixel 10 with stb high:
  - stb/cyc go 0 asynchronously; state = IDLE; FRAME_CNT = 0.
  - The next START writes from BASE_ADR again.
- AUTO=1, PATTERN=3, COLOR=16'h1234:
  - Continuous refills, all data 16'h1234.
  - One idle cycle (DONE) plus one IDLE cycle between frames.
  - FRAME_CNT wraps 255->0.

Source files
------------

// File: rtl/mire_wb_writer.sv
`timescale 1ns/1ps
// Wishbone master that paints one test-pattern frame into the framebuffer,
// one RGB565 pixel per acked write, in raster order from BASE_ADR.
module mire_wb_writer #(
  parameter int          HDISP    = 640,
  parameter int          VDISP    = 480,
  parameter logic [31:0] BASE_ADR = 32'h0,
  parameter bit          AUTO     = 1'b0
) (
  input  logic        CLK,
  input  logic        RST_N,
  input  logic        START,
  input  logic [1:0]  PATTERN,
  input  logic        SCROLL,
  input  logic [15:0] COLOR,
  output logic        BUSY,
  output logic        DONE,
  output logic [7:0]  FRAME_CNT,
  output logic        wb_cyc,
  output logic        wb_stb,
  output logic        wb_we,
  output logic [1:0]  wb_sel,
  output logic [31:0] wb_adr,
  output logic [15:0] wb_dat_ms,
  input  logic        wb_ack
);

  typedef enum logic [1:0] {S_IDLE, S_WRITE, S_DONE} state_t;

  localparam int               NPIX     = HDISP * VDISP;
  localparam int               PIX_W    = (NPIX > 1) ? $clog2(NPIX) : 1;
  localparam int               BAR_W    = HDISP / 8;
  localparam logic [15:0]      X_LAST   = 16'(HDISP - 1);
  localparam logic [15:0]      BAR_LAST = 16'(BAR_W - 1);
  localparam logic [PIX_W-1:0] PIX_LAST = PIX_W'(NPIX - 1);

  state_t            state_q, state_d;
  logic [15:0]       x_q, x_d, y_q, y_d;
  logic [PIX_W-1:0]  pix_q, pix_d;
  logic [15:0]       bc_q, bc_d;
  logic [2:0]        bi_q, bi_d;
  logic [7:0]        frame_q, frame_d;
  logic [31:0]       adr_q, adr_d;
  logic [15:0]       dat_q, dat_d;

  logic [1:0]        pat_q;
  logic [15:0]       color_q;
  logic [9:0]        off_q;

  logic              go;
  logic [9:0]        off_start;
  logic [15:0]       x_nx, y_nx, bc_nx;
  logic [2:0]        bi_nx;
  logic [PIX_W-1:0]  pix_nx;

  function automatic logic [15:0] pixel_color(input logic [1:0]  pat,
                                              input logic [15:0] x,
                                              input logic [9:0]  off,
                                              input logic [15:0] y,
                                              input logic [2:0]  bar,
                                              input logic [15:0] col);
    logic [9:0] xs;
    xs = x[9:0] + off;
    case (pat)
      2'd0: begin
        case (bar)
          3'd0:    pixel_color = 16'hFFFF;
          3'd1:    pixel_color = 16'h07FF;
          3'd2:    pixel_color = 16'hFFE0;
          3'd3:    pixel_color = 16'h07E0;
          3'd4:    pixel_color = 16'hF81F;
          3'd5:    pixel_color = 16'h001F;
          3'd6:    pixel_color = 16'hF800;
          default: pixel_color = 16'h0000;
        endcase
      end
      2'd1:    pixel_color = (xs[5] ^ y[5]) ? 16'hFFFF : 16'h0000;
      2'd2:    pixel_color = {~xs[9:5], y[8:3], xs[9:5]};
      default: pixel_color = col;
    endcase
  endfunction

  assign go        = START | AUTO;
  assign off_start = SCROLL ? {FRAME_CNT, 2'b00} : 10'd0;

  // Coordinates of the pixel after the current one; the bar index walks with
  // x so pattern 0 needs no divider.
  always_comb begin
    pix_nx = pix_q + 1'b1;
    y_nx   = y_q;
    bi_nx  = bi_q;
    if (x_q == X_LAST) begin
      x_nx  = 16'd0;
      y_nx  = y_q + 16'd1;
      bc_nx = 16'd0;
      bi_nx = 3'd0;
    end else begin
      x_nx = x_q + 16'd1;
      if (bc_q == BAR_LAST) begin
        bc_nx = 16'd0;
        bi_nx = bi_q + 3'd1;
      end else begin
        bc_nx = bc_q + 16'd1;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    y_d     = y_q;
    pix_d   = pix_q;
    bc_d    = bc_q;
    bi_d    = bi_q;
    frame_d = frame_q;
    adr_d   = adr_q;
    dat_d   = dat_q;
    case (state_q)
      S_IDLE: begin
        if (go) begin
          state_d = S_WRITE;
          x_d     = 16'd0;
          y_d     = 16'd0;
          pix_d   = '0;
          bc_d    = 16'd0;
          bi_d    = 3'd0;
          adr_d   = BASE_ADR;
          dat_d   = pixel_color(PATTERN, 16'd0, off_start, 16'd0, 3'd0, COLOR);
        end
      end
      S_WRITE: begin
        if (wb_ack) begin
          pix_d = pix_nx;
          x_d   = x_nx;
          y_d   = y_nx;
          bc_d  = bc_nx;
          bi_d  = bi_nx;
          if (pix_q == PIX_LAST) begin
            state_d = S_DONE;
          end else begin
            // Next beat is ready on the cycle after the ack: zero-wait slaves
            // see one pixel per clock.
            adr_d = BASE_ADR + 32'({pix_nx, 1'b0});
            dat_d = pixel_color(pat_q, x_nx, off_q, y_nx, bi_nx, color_q);
          end
        end
      end
      S_DONE: begin
        frame_d = frame_q + 8'd1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q <= S_IDLE;
      x_q     <= 16'd0;
      y_q     <= 16'd0;
      pix_q   <= '0;
      bc_q    <= 16'd0;
      bi_q    <= 3'd0;
      frame_q <= 8'd0;
      adr_q   <= 32'd0;
      dat_q   <= 16'd0;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      y_q     <= y_d;
      pix_q   <= pix_d;
      bc_q    <= bc_d;
      bi_q    <= bi_d;
      frame_q <= frame_d;
      adr_q   <= adr_d;
      dat_q   <= dat_d;
    end
  end

  // Frame settings are only consumed in WRITE, so they carry no reset.
  always_ff @(posedge CLK) begin
    if (state_q == S_IDLE && go) begin
      pat_q   <= PATTERN;
      color_q <= COLOR;
      off_q   <= off_start;
    end
  end

  assign wb_cyc    = (state_q == S_WRITE);
  assign wb_stb    = (state_q == S_WRITE);
  assign wb_we     = 1'b1;
  assign wb_sel    = 2'b11;
  assign wb_adr    = adr_q;
  assign wb_dat_ms = dat_q;
  assign BUSY      = (state_q != S_IDLE);
  assign DONE      = (state_q == S_DONE);
  assign FRAME_CNT = frame_q;

endmodule

// File: tb/tb_mire_wb_writer.sv
`timescale 1ns/1ps
// Bench for mire_wb_writer: three instances (small manual, scroll, auto-refill)
// checked pixel by pixel against a raster-order reference model.
module tb_mire_wb_writer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n, rst_c_n, c_rst;
  logic        start, scroll, ack;
  logic [1:0]  pattern;
  logic [15:0] color;
  int          sel;

  logic        st [3];
  logic        ak [3];
  logic        busy [3], done [3], cyc [3], stb [3], we [3];
  logic [7:0]  fc [3];
  logic [1:0]  bsel [3];
  logic [31:0] adr [3];
  logic [15:0] dat [3];

  logic [7:0]  exp_fc [3];
  logic [15:0] got [0:127];
  int          total = 0;
  int          bad = 0;
  int          cycles = 0;

  always @(posedge clk) cycles <= cycles + 1;

  assign st[0] = start && (sel == 0);
  assign st[1] = start && (sel == 1);
  assign st[2] = start && (sel == 2);
  assign ak[0] = ack && (sel == 0);
  assign ak[1] = ack && (sel == 1);
  assign ak[2] = ack && (sel == 2);
  assign c_rst = rst_n & rst_c_n;

  mire_wb_writer #(.HDISP(16), .VDISP(4), .BASE_ADR(32'h0), .AUTO(1'b0)) u_a (
    .CLK(clk), .RST_N(rst_n), .START(st[0]), .PATTERN(pattern), .SCROLL(scroll),
    .COLOR(color), .BUSY(busy[0]), .DONE(done[0]), .FRAME_CNT(fc[0]),
    .wb_cyc(cyc[0]), .wb_stb(stb[0]), .wb_we(we[0]), .wb_sel(bsel[0]),
    .wb_adr(adr[0]), .wb_dat_ms(dat[0]), .wb_ack(ak[0]));

  mire_wb_writer #(.HDISP(64), .VDISP(2), .BASE_ADR(32'h0010_0000), .AUTO(1'b0)) u_b (
    .CLK(clk), .RST_N(rst_n), .START(st[1]), .PATTERN(pattern), .SCROLL(scroll),
    .COLOR(color), .BUSY(busy[1]), .DONE(done[1]), .FRAME_CNT(fc[1]),
    .wb_cyc(cyc[1]), .wb_stb(stb[1]), .wb_we(we[1]), .wb_sel(bsel[1]),
    .wb_adr(adr[1]), .wb_dat_ms(dat[1]), .wb_ack(ak[1]));

  mire_wb_writer #(.HDISP(8), .VDISP(2), .BASE_ADR(32'hFFFF_FFF0), .AUTO(1'b1)) u_c (
    .CLK(clk), .RST_N(c_rst), .START(st[2]), .PATTERN(pattern), .SCROLL(scroll),
    .COLOR(color), .BUSY(busy[2]), .DONE(done[2]), .FRAME_CNT(fc[2]),
    .wb_cyc(cyc[2]), .wb_stb(stb[2]), .wb_we(we[2]), .wb_sel(bsel[2]),
    .wb_adr(adr[2]), .wb_dat_ms(dat[2]), .wb_ack(ak[2]));

  function automatic int hd(input int s);
    return (s == 0) ? 16 : (s == 1) ? 64 : 8;
  endfunction
  function automatic int vd(input int s);
    return (s == 0) ? 4 : 2;
  endfunction
  function automatic logic [31:0] base(input int s);
    return (s == 0) ? 32'h0 : (s == 1) ? 32'h0010_0000 : 32'hFFFF_FFF0;
  endfunction

  function automatic logic [15:0] model_pix(input int h, input int x, input int y,
                                            input int pat, input int off,
                                            input logic [15:0] col);
    int xs, r, g;
    xs = (x + off) % 1024;
    case (pat)
      0: begin
        case (x / (h / 8))
          0: return 16'hFFFF;
          1: return 16'h07FF;
          2: return 16'hFFE0;
          3: return 16'h07E0;
          4: return 16'hF81F;
          5: return 16'h001F;
          6: return 16'hF800;
          default: return 16'h0000;
        endcase
      end
      1: return ((((xs / 32) % 2) ^ ((y / 32) % 2)) != 0) ? 16'hFFFF : 16'h0000;
      2: begin
        r = xs / 32;
        g = (y / 8) % 64;
        return 16'((31 - r) * 2048 + g * 32 + r);
      end
      default: return col;
    endcase
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // Plays the slave for one frame. start_wait >= 0 checks cycles until the
  // first strobe; abort_at >= 0 resets the block while that pixel is pending.
  task automatic run_frame(input int s, input int pat, input int off,
                           input logic [15:0] col, input bit rnd,
                           input int start_wait, input int start_mid,
                           input bit start_in_done, input int abort_at);
    int h, n_pix, waited, d;
    logic [31:0] ref_adr, hold_a;
    logic [15:0] ref_dat, hold_d;
    h = hd(s);
    n_pix = h * vd(s);
    for (int n = 0; n < n_pix; n++) begin
      waited = 0;
      while (stb[s] !== 1'b1 && waited < 50) begin
        tick();
        waited++;
      end
      total++;
      if (stb[s] !== 1'b1) begin
        bad++;
        $display("FAIL strobe_timeout pixel %0d: stb=%b required 1", n, stb[s]);
        return;
      end
      if (n == 0 && start_wait >= 0) begin
        total++;
        if (waited != start_wait) begin
          bad++;
          $display("FAIL start_latency: %0d cycles, required %0d", waited, start_wait);
        end
      end
      ref_adr = base(s) + 32'(2 * n);
      ref_dat = model_pix(h, n % h, n / h, pat, off, col);
      total++;
      if (adr[s] !== ref_adr) begin
        bad++;
        $display("FAIL adr pixel %0d: got %h required %h", n, adr[s], ref_adr);
      end
      total++;
      if (dat[s] !== ref_dat) begin
        bad++;
        $display("FAIL dat pixel %0d: got %h required %h", n, dat[s], ref_dat);
      end
      got[n] = dat[s];
      if (n == abort_at) begin
        ack = 1'b1;
        #1 rst_n = 1'b0;
        #1;
        total++;
        if (stb[s] !== 1'b0 || cyc[s] !== 1'b0 || busy[s] !== 1'b0 ||
            fc[s] !== 8'd0 || adr[s] !== 32'd0 || dat[s] !== 16'd0) begin
          bad++;
          $display("FAIL async_reset: stb=%b cyc=%b busy=%b fc=%0d adr=%h dat=%h required all 0",
                   stb[s], cyc[s], busy[s], fc[s], adr[s], dat[s]);
        end
        tick();
        ack = 1'b0;
        rst_n = 1'b1;
        exp_fc[0] = 8'd0;
        exp_fc[1] = 8'd0;
        return;
      end
      if (rnd) begin
        d = $urandom_range(0, 5);
        hold_a = adr[s];
        hold_d = dat[s];
        repeat (d) begin
          ack = 1'b0;
          tick();
          total++;
          if (stb[s] !== 1'b1 || adr[s] !== hold_a || dat[s] !== hold_d) begin
            bad++;
            $display("FAIL stable_wait pixel %0d: stb=%b adr=%h dat=%h required 1 %h %h",
                     n, stb[s], adr[s], dat[s], hold_a, hold_d);
          end
        end
      end
      if (n == start_mid) start = 1'b1;
      ack = 1'b1;
      tick();
      ack = 1'b0;
      start = 1'b0;
    end
    total++;
    if (done[s] !== 1'b1 || busy[s] !== 1'b1 || stb[s] !== 1'b0) begin
      bad++;
      $display("FAIL done_pulse: done=%b busy=%b stb=%b required 1 1 0", done[s], busy[s], stb[s]);
    end
    exp_fc[s] = exp_fc[s] + 8'd1;
    if (start_in_done) start = 1'b1;
    tick();
    start = 1'b0;
    total++;
    if (done[s] !== 1'b0 || busy[s] !== 1'b0 || fc[s] !== exp_fc[s]) begin
      bad++;
      $display("FAIL after_done: done=%b busy=%b fc=%0d required 0 0 %0d",
               done[s], busy[s], fc[s], exp_fc[s]);
    end
  endtask

  task automatic test_reset();
    repeat (3) tick();
    for (int s = 0; s < 3; s++) begin
      total++;
      if (busy[s] !== 1'b0 || done[s] !== 1'b0 || cyc[s] !== 1'b0 || stb[s] !== 1'b0 ||
          fc[s] !== 8'd0 || adr[s] !== 32'd0 || dat[s] !== 16'd0 ||
          we[s] !== 1'b1 || bsel[s] !== 2'b11) begin
        bad++;
        $display("FAIL reset_state dut %0d: busy=%b done=%b cyc=%b stb=%b fc=%0d adr=%h dat=%h we=%b sel=%b",
                 s, busy[s], done[s], cyc[s], stb[s], fc[s], adr[s], dat[s], we[s], bsel[s]);
      end
    end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_pattern0();
    int c0;
    sel = 0;
    pattern = 2'd0;
    scroll = 1'b0;
    pulse_start();
    c0 = cycles;
    pattern = 2'd2;
    run_frame(0, 0, 0, 16'h0, 1'b0, 0, -1, 1'b0, -1);
    total++;
    if (cycles - c0 != 65) begin
      bad++;
      $display("FAIL back_to_back: %0d cycles, required 65", cycles - c0);
    end
  endtask

  task automatic test_wait_states();
    sel = 0;
    pattern = 2'd0;
    pulse_start();
    pattern = 2'($urandom_range(1, 3));
    run_frame(0, 0, 0, 16'h0, 1'b1, 0, -1, 1'b0, -1);
  endtask

  task automatic test_start_ignored();
    sel = 0;
    pattern = 2'd0;
    pulse_start();
    run_frame(0, 0, 0, 16'h0, 1'b1, 0, 20, 1'b1, -1);
    repeat (5) tick();
    total++;
    if (busy[0] !== 1'b0 || stb[0] !== 1'b0 || fc[0] !== exp_fc[0]) begin
      bad++;
      $display("FAIL start_dropped: busy=%b stb=%b fc=%0d required 0 0 %0d",
               busy[0], stb[0], fc[0], exp_fc[0]);
    end
  endtask

  task automatic test_reset_midframe();
    sel = 0;
    pattern = 2'd0;
    pulse_start();
    run_frame(0, 0, 0, 16'h0, 1'b0, 0, -1, 1'b0, 10);
    tick();
    pulse_start();
    run_frame(0, 0, 0, 16'h0, 1'b0, 0, -1, 1'b0, -1);
  endtask

  task automatic test_scroll();
    int off;
    sel = 1;
    pattern = 2'd1;
    scroll = 1'b1;
    for (int k = 0; k < 3; k++) begin
      off = 4 * int'(exp_fc[1]);
      pulse_start();
      run_frame(1, 1, off, 16'h0, 1'b0, 0, -1, 1'b0, -1);
      total++;
      if (got[0] !== 16'h0000) begin
        bad++;
        $display("FAIL scroll_origin frame %0d: got %h required 0000", k, got[0]);
      end
      if (k == 0) begin
        total++;
        if (got[32] !== 16'hFFFF) begin
          bad++;
          $display("FAIL scroll_x32 frame 0: got %h required ffff", got[32]);
        end
      end
    end
    total++;
    if (fc[1] !== 8'd3) begin
      bad++;
      $display("FAIL scroll_frame_cnt: got %0d required 3", fc[1]);
    end
  endtask

  task automatic test_random_frames();
    int pat, off;
    sel = 1;
    for (int k = 0; k < 4; k++) begin
      pat = $urandom_range(0, 3);
      pattern = 2'(pat);
      scroll = 1'($urandom_range(0, 1));
      color = 16'($urandom);
      off = scroll ? 4 * int'(exp_fc[1]) : 0;
      pulse_start();
      pattern = 2'($urandom);
      scroll = 1'($urandom);
      run_frame(1, pat, off, color, 1'b1, 0, -1, 1'b0, -1);
      color = 16'($urandom);
    end
  endtask

  task automatic test_auto();
    sel = 2;
    pattern = 2'd3;
    scroll = 1'b0;
    color = 16'h1234;
    rst_c_n = 1'b1;
    run_frame(2, 3, 0, 16'h1234, 1'b0, -1, -1, 1'b0, -1);
    for (int k = 1; k < 256; k++) begin
      run_frame(2, 3, 0, 16'h1234, 1'b0, 1, -1, 1'b0, -1);
    end
    total++;
    if (fc[2] !== 8'd0) begin
      bad++;
      $display("FAIL auto_wrap: got %0d required 0", fc[2]);
    end
    run_frame(2, 3, 0, 16'h1234, 1'b0, 1, -1, 1'b0, -1);
  endtask

  initial begin
    rst_n = 1'b0;
    rst_c_n = 1'b0;
    start = 1'b0;
    ack = 1'b0;
    sel = 0;
    pattern = 2'd0;
    scroll = 1'b0;
    color = 16'h0;
    for (int s = 0; s < 3; s++) exp_fc[s] = 8'd0;
    test_reset();
    test_pattern0();
    test_wait_states();
    test_start_ignored();
    test_reset_midframe();
    test_scroll();
    test_random_frames();
    test_auto();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
